// File: rtl/obg_bitgen_pkg.sv
// Shared constants, rate lookup and SIGNAL-field packing for the OFDM bit generator.
package obg_bitgen_pkg;

  localparam int unsigned SIG_W     = 24;
  localparam int unsigned SERVICE_W = 16;
  localparam int unsigned TAIL_W    = 6;
  localparam int unsigned LEN_W     = 12;
  localparam int unsigned TYPE_W    = 4;
  localparam int unsigned CNT_W     = 18;
  localparam int unsigned DBPS_W    = 8;
  localparam int unsigned INIT_W    = 6;
  localparam int unsigned SCR_W     = 7;
  localparam int unsigned PRBS_W    = 9;

  // x^7+x^4+1 and x^9+x^5+1 feedback taps (state bit indices)
  localparam int unsigned SCR_TAP_HI  = 6;
  localparam int unsigned SCR_TAP_LO  = 3;
  localparam int unsigned PRBS_TAP_HI = 8;
  localparam int unsigned PRBS_TAP_LO = 4;

  localparam logic [SCR_W-1:0]  SCR_SEED_DFLT  = 7'b1011101;
  localparam logic [PRBS_W-1:0] PRBS_SEED_DFLT = 9'h1FF;

  localparam logic [TYPE_W-1:0] RATE_6  = 4'b1011;
  localparam logic [TYPE_W-1:0] RATE_9  = 4'b1111;
  localparam logic [TYPE_W-1:0] RATE_12 = 4'b1010;
  localparam logic [TYPE_W-1:0] RATE_18 = 4'b1110;
  localparam logic [TYPE_W-1:0] RATE_24 = 4'b1001;
  localparam logic [TYPE_W-1:0] RATE_36 = 4'b1101;
  localparam logic [TYPE_W-1:0] RATE_48 = 4'b1000;
  localparam logic [TYPE_W-1:0] RATE_54 = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SIG  = 2'd1,
    ST_PLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [TYPE_W-1:0] rate;
  } frame_cfg_t;

  // N_DBPS for a rate code; zero marks an invalid code
  function automatic logic [DBPS_W-1:0] rate_ndbps(input logic [TYPE_W-1:0] rate);
    logic [DBPS_W-1:0] n;
    case (rate)
      RATE_6:  n = DBPS_W'(24);
      RATE_9:  n = DBPS_W'(36);
      RATE_12: n = DBPS_W'(48);
      RATE_18: n = DBPS_W'(72);
      RATE_24: n = DBPS_W'(96);
      RATE_36: n = DBPS_W'(144);
      RATE_48: n = DBPS_W'(192);
      RATE_54: n = DBPS_W'(216);
      default: n = '0;
    endcase
    return n;
  endfunction

  // SIGNAL word, bit 0 transmitted first
  function automatic logic [SIG_W-1:0] sig_word(input logic [TYPE_W-1:0] rate,
                                                input logic [LEN_W-1:0]  len);
    logic [SIG_W-1:0] w;
    w        = '0;
    w[3:0]   = rate;
    w[16:5]  = len;
    w[17]    = ^w[16:0];
    return w;
  endfunction

endpackage

// File: rtl/obg_scrambler.sv
// 7-bit x^7+x^4+1 LFSR keystream with synchronous load and advance enable.
module obg_scrambler
  import obg_bitgen_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SCR_W-1:0] seed,
  output logic             ks_c
);

  logic [SCR_W-1:0] s_q;

  assign ks_c = s_q[SCR_TAP_HI] ^ s_q[SCR_TAP_LO];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= SCR_SEED_DFLT;
    end else if (load) begin
      s_q <= seed;
    end else if (en) begin
      s_q <= {s_q[SCR_W-2:0], ks_c};
    end
  end

endmodule

// File: rtl/obg_bitgen.sv
// OFDM bit generator: captures rate/length, emits the SIGNAL field then the
// scrambled SERVICE/PSDU/tail/pad DATA field back-to-back.
module obg_bitgen
  import obg_bitgen_pkg::*;
#(
  parameter logic [SCR_W-1:0]  SCR_SEED  = SCR_SEED_DFLT,
  parameter logic [PRBS_W-1:0] PRBS_SEED = PRBS_SEED_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       ssg_di_len,
  input  logic [TYPE_W-1:0] ssg_di_type,
  input  logic              ssg_di_vld,
  input  logic              new_frame,
  output logic [INIT_W-1:0] ssg_do_init,
  output logic              ssg_do,
  output logic              ssg_do_vld,
  output logic              pld_do,
  output logic              pld_do_vld
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DBPS_W-1:0]   sym_q, sym_d;
  logic [DBPS_W-1:0]   ndbps_q, ndbps_d;
  frame_cfg_t          cfg_q, cfg_d;
  logic [SIG_W-2:0]    sr_q, sr_d;
  logic [PRBS_W-1:0]   prbs_q, prbs_d;
  logic [INIT_W-1:0]   init_d;
  logic                ssg_do_d, ssg_do_vld_d, pld_do_d, pld_do_vld_d;

  logic [DBPS_W-1:0]   new_ndbps;
  logic [SIG_W-1:0]    sig_w;
  logic [CNT_W-1:0]    data_end, frame_need, emit_idx;
  logic                capture, sym_last, prbs_bit;
  logic                emit_pld, in_data, in_tail;
  logic                scr_load, scr_en, scr_ks_c;
  logic                unused_len_hi;

  assign unused_len_hi = ^ssg_di_len[15:12];

  assign new_ndbps  = rate_ndbps(ssg_di_type);
  assign capture    = (state_q == ST_IDLE) && ssg_di_vld && (new_ndbps != '0);
  assign sig_w      = sig_word(ssg_di_type, ssg_di_len[LEN_W-1:0]);
  assign data_end   = CNT_W'(SERVICE_W) + CNT_W'({cfg_q.len, 3'b000});
  assign frame_need = data_end + CNT_W'(TAIL_W);
  assign sym_last   = (sym_q == ndbps_q - DBPS_W'(1));
  assign prbs_bit   = prbs_q[PRBS_TAP_HI] ^ prbs_q[PRBS_TAP_LO];

  obg_scrambler u_scr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (scr_load),
    .en    (scr_en),
    .seed  (SCR_SEED),
    .ks_c  (scr_ks_c)
  );

  // Next-state and next-output logic; outputs are registered with the state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sym_d        = sym_q;
    ndbps_d      = ndbps_q;
    cfg_d        = cfg_q;
    sr_d         = sr_q;
    prbs_d       = prbs_q;
    init_d       = ssg_do_init;
    ssg_do_d     = 1'b0;
    ssg_do_vld_d = 1'b0;
    pld_do_d     = 1'b0;
    pld_do_vld_d = 1'b0;
    scr_load     = 1'b0;
    scr_en       = 1'b0;
    emit_pld     = 1'b0;
    emit_idx     = '0;
    in_data      = 1'b0;
    in_tail      = 1'b0;

    if (capture) begin
      state_d      = ST_SIG;
      cnt_d        = '0;
      sym_d        = '0;
      ndbps_d      = new_ndbps;
      cfg_d.len    = ssg_di_len[LEN_W-1:0];
      cfg_d.rate   = ssg_di_type;
      init_d       = INIT_W'(new_ndbps >> 2);
      ssg_do_d     = sig_w[0];
      ssg_do_vld_d = 1'b1;
      sr_d         = sig_w[SIG_W-1:1];
      prbs_d       = PRBS_SEED;
      scr_load     = 1'b1;
    end else if (new_frame) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sym_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SIG: begin
          if (cnt_q == CNT_W'(SIG_W - 1)) begin
            state_d  = ST_PLD;
            cnt_d    = '0;
            sym_d    = '0;
            emit_pld = 1'b1;
          end else begin
            cnt_d        = cnt_q + CNT_W'(1);
            ssg_do_d     = sr_q[0];
            ssg_do_vld_d = 1'b1;
            sr_d         = sr_q >> 1;
          end
        end
        ST_PLD: begin
          // Frame ends on a symbol boundary once tail has been sent
          if (sym_last && (cnt_q + CNT_W'(1) >= frame_need)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sym_d   = '0;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            sym_d    = sym_last ? '0 : sym_q + DBPS_W'(1);
            emit_pld = 1'b1;
            emit_idx = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (emit_pld) begin
      in_data      = (emit_idx >= CNT_W'(SERVICE_W)) && (emit_idx < data_end);
      in_tail      = (emit_idx >= data_end) && (emit_idx < frame_need);
      scr_en       = 1'b1;
      pld_do_d     = ((in_data & prbs_bit) ^ scr_ks_c) & ~in_tail;
      pld_do_vld_d = 1'b1;
      if (in_data) begin
        prbs_d = {prbs_q[PRBS_W-2:0], prbs_bit};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sym_q       <= '0;
      ndbps_q     <= '0;
      cfg_q       <= '0;
      sr_q        <= '0;
      prbs_q      <= PRBS_SEED;
      ssg_do_init <= '0;
      ssg_do      <= 1'b0;
      ssg_do_vld  <= 1'b0;
      pld_do      <= 1'b0;
      pld_do_vld  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_q       <= sym_d;
      ndbps_q     <= ndbps_d;
      cfg_q       <= cfg_d;
      sr_q        <= sr_d;
      prbs_q      <= prbs_d;
      ssg_do_init <= init_d;
      ssg_do      <= ssg_do_d;
      ssg_do_vld  <= ssg_do_vld_d;
      pld_do      <= pld_do_d;
      pld_do_vld  <= pld_do_vld_d;
    end
  end

endmodule

// File: tb/tb_obg_bitgen.sv
// Directed bench for obg_bitgen: SIGNAL/payload framing, scrambling, abort and reset.
module tb_obg_bitgen;

  localparam int unsigned MAXB = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ssg_di_len;
  logic [3:0]  ssg_di_type;
  logic        ssg_di_vld;
  logic        new_frame;
  logic [5:0]  ssg_do_init;
  logic        ssg_do, ssg_do_vld, pld_do, pld_do_vld;

  always #5 clk = ~clk;

  obg_bitgen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ssg_di_len  (ssg_di_len),
    .ssg_di_type (ssg_di_type),
    .ssg_di_vld  (ssg_di_vld),
    .new_frame   (new_frame),
    .ssg_do_init (ssg_do_init),
    .ssg_do      (ssg_do),
    .ssg_do_vld  (ssg_do_vld),
    .pld_do      (pld_do),
    .pld_do_vld  (pld_do_vld)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [23:0] sig_got;
  int          sig_n, sig_first, pld_n, pld_first, pld_last, stray, overlap, hits;
  bit          timed_out, seen;
  logic        pld_got [MAXB];
  logic [6:0]  first7;
  logic        tail_or;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] sig_model(input logic [3:0] t, input logic [11:0] le);
    logic [23:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[i] = t[i];
    for (int i = 0; i < 12; i++) w[5+i] = le[i];
    w[17] = ^w[16:0];
    return w;
  endfunction

  function automatic int pld_errs(input int le, input int n);
    logic [6:0] s;
    logic [8:0] p;
    logic       d, ks, o;
    int         e;
    s = 7'b1011101;
    p = 9'h1FF;
    e = 0;
    for (int i = 0; i < n; i++) begin
      d = 1'b0;
      if (i >= 16 && i < 16 + 8*le) begin
        d = p[8] ^ p[4];
        p = {p[7:0], d};
      end
      ks = s[6] ^ s[3];
      s  = {s[5:0], ks};
      o  = d ^ ks;
      if (i >= 16 + 8*le && i < 22 + 8*le) o = 1'b0;
      if (i < MAXB && pld_got[i] !== o) e++;
    end
    return e;
  endfunction

  task automatic count_vld(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (ssg_do_vld || pld_do_vld || ssg_do || pld_do) n++;
    end
  endtask

  // Samples one frame from the cycle after capture until pld_do_vld falls
  task automatic collect(input int max_cyc, input bit poke);
    sig_got = '0; sig_n = 0; sig_first = 0; pld_n = 0; pld_first = 0; pld_last = 0;
    stray = 0; overlap = 0; timed_out = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (ssg_do_vld) begin
        if (sig_n == 0) sig_first = c;
        if (sig_n < 24) sig_got[sig_n] = ssg_do;
        sig_n++;
      end else if (ssg_do) stray++;
      if (pld_do_vld) begin
        if (pld_n == 0) pld_first = c;
        if (pld_n < MAXB) pld_got[pld_n] = pld_do;
        pld_n++;
        pld_last = c;
      end else if (pld_do) stray++;
      if (ssg_do_vld && pld_do_vld) overlap++;
      if (poke && c == 10) begin ssg_di_vld = 1'b1; ssg_di_type = 4'b1000; end
      if (poke && c == 11) ssg_di_vld = 1'b0;
      if (pld_n > 0 && !pld_do_vld) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [3:0] t, input logic [15:0] l, input int nd, input bit poke);
    int le, n;
    le = int'(l[11:0]);
    n  = ((22 + 8*le + nd - 1) / nd) * nd;
    ssg_di_type = t;
    ssg_di_len  = l;
    ssg_di_vld  = 1'b1;
    @(posedge clk);
    #1 ssg_di_vld = 1'b0;
    collect(n + 100, poke);
    check("timeout",   32'(timed_out), 0);
    check("init",      32'(ssg_do_init), nd / 4);
    check("sig_word",  32'(sig_got), 32'(sig_model(t, l[11:0])));
    check("sig_first", sig_first, 1);
    check("sig_len",   sig_n, 24);
    check("pld_first", pld_first, 25);
    check("pld_len",   pld_n, n);
    check("pld_last",  pld_last, 24 + n);
    check("stray_bit", stray, 0);
    check("overlap",   overlap, 0);
    check("pld_bits",  pld_errs(le, n), 0);
  endtask

  initial begin
    rst_n = 1'b0; ssg_di_len = '0; ssg_di_type = '0; ssg_di_vld = 1'b0; new_frame = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {22'b0, ssg_do, ssg_do_vld, pld_do, pld_do_vld, ssg_do_init}, 0);
    rst_n = 1'b1;
    count_vld(10, hits);
    check("idle_after_rst", hits, 0);

    // 6 Mbps, LEN=100: 840 payload bits, tail at 816..821
    run_frame(4'b1011, 16'd100, 24, 1'b0);
    check("sig_6m_const", 32'(sig_got), 32'h000c8b);
    tail_or = 1'b0;
    for (int i = 816; i < 822; i++) tail_or = tail_or | pld_got[i];
    check("tail_zero", 32'(tail_or), 0);

    // 54 Mbps, LEN=1, requested back-to-back; a mid-SIG request must be ignored
    run_frame(4'b1100, 16'd1, 216, 1'b1);
    for (int i = 0; i < 7; i++) first7[6-i] = pld_got[i];
    check("scr_keystream", 32'(first7), 32'(7'b0110110));

    // invalid rate code is ignored
    ssg_di_type = 4'b0000; ssg_di_len = 16'd7; ssg_di_vld = 1'b1;
    @(posedge clk);
    #1 ssg_di_vld = 1'b0;
    count_vld(40, hits);
    check("invalid_no_vld", hits, 0);
    check("invalid_init_kept", 32'(ssg_do_init), 54);
    run_frame(4'b1111, 16'd5, 36, 1'b0);

    // capture with new_frame high, then abort mid-PLD
    ssg_di_type = 4'b1010; ssg_di_len = 16'd10; ssg_di_vld = 1'b1; new_frame = 1'b1;
    @(posedge clk);
    #1 ssg_di_vld = 1'b0; new_frame = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (pld_do_vld) seen = 1'b1;
    end
    check("abort_pld_start", 32'(seen), 1);
    repeat (5) @(negedge clk);
    new_frame = 1'b1;
    @(posedge clk);
    #1 new_frame = 1'b0;
    @(negedge clk);
    check("abort_drop", {30'b0, ssg_do_vld, pld_do_vld}, 0);
    check("abort_init_kept", 32'(ssg_do_init), 12);
    count_vld(10, hits);
    check("abort_idle", hits, 0);
    run_frame(4'b1110, 16'd3, 72, 1'b0);

    // asynchronous reset mid-SIG
    ssg_di_type = 4'b1011; ssg_di_len = 16'd2; ssg_di_vld = 1'b1;
    @(posedge clk);
    #1 ssg_di_vld = 1'b0;
    repeat (5) @(negedge clk);
    check("sig_active_pre_rst", 32'(ssg_do_vld), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {22'b0, ssg_do, ssg_do_vld, pld_do, pld_do_vld, ssg_do_init}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_vld(40, hits);
    check("rst_no_residual", hits, 0);

    // LEN=0 with upper length bits set (ignored): one 192-bit symbol
    run_frame(4'b1000, 16'hF000, 192, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
